// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Brief    : ID-stage decode, branch/halt requests and hazard-control outputs.
// Revision : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        ex_branch_taken;
    logic        halt_req;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        halt_ack;
    logic [15:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_reg_write,
               id_mem_read, ex_branch_taken, halt_req,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
               halt_ack, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_reg_write,
               id_mem_read, ex_branch_taken, halt_req,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
               halt_ack, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : 5-stage pipeline hazard unit: load-use stall, forwarding, branch
//            flush and halt/drain sequencing.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl (
    input  wire logic     clk,
    input  wire logic     rst,
    hazard_ctrl_if.slave  bus
);
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs2;
        logic       reg_write;
        logic       mem_read;
    } stage_t;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    stage_t      r_ex;
    stage_t      r_mem;
    stage_t      r_wb;
    logic [15:0] r_stall_cnt;
    logic        w_lu;
    logic        w_count_stall;
    logic        w_bubble;

    // A producer in MEM is newer than one in WB, so it is tested first.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input stage_t mem,
                                           input stage_t wb);
        if (mem.valid && mem.reg_write && (mem.rd != 5'd0) && (mem.rd == src))
            return 2'b10;
        else if (wb.valid && wb.reg_write && (wb.rd != 5'd0) && (wb.rd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_lu = r_ex.valid && r_ex.mem_read && (r_ex.rd != 5'd0) && bus.id_valid &&
               ((r_ex.rd == bus.id_rs1) || (bus.id_uses_rs2 && (r_ex.rd == bus.id_rs2)));

        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.if_id_flush  = 1'b0;
        w_bubble         = 1'b0;
        bus.halt_ack     = 1'b0;
        w_count_stall    = 1'b0;
        w_next_state     = r_state;

        if (!rst) begin
            case (r_state)
                S_RUN: begin
                    if (bus.ex_branch_taken) begin
                        bus.if_id_flush = 1'b1;
                        w_bubble        = 1'b1;
                    end else if (w_lu) begin
                        bus.pc_write    = 1'b0;
                        bus.if_id_write = 1'b0;
                        w_bubble        = 1'b1;
                        w_count_stall   = 1'b1;
                    end
                    if (bus.halt_req)
                        w_next_state = S_DRAIN;
                end
                S_DRAIN: begin
                    bus.pc_write    = 1'b0;
                    bus.if_id_write = 1'b0;
                    w_bubble        = 1'b1;
                    // A branch already in EX must still redirect fetch while draining.
                    if (bus.ex_branch_taken) begin
                        bus.pc_write    = 1'b1;
                        bus.if_id_flush = 1'b1;
                    end
                    if (!bus.halt_req)
                        w_next_state = S_RUN;
                    else if (!r_ex.valid && !r_mem.valid && !r_wb.valid)
                        w_next_state = S_HALTED;
                end
                S_HALTED: begin
                    bus.pc_write    = 1'b0;
                    bus.if_id_write = 1'b0;
                    w_bubble        = 1'b1;
                    bus.halt_ack    = 1'b1;
                    if (!bus.halt_req)
                        w_next_state = S_RUN;
                end
                default: w_next_state = S_RUN;
            endcase
        end
    end

    assign bus.id_ex_bubble = w_bubble;
    assign bus.fwd_a        = fwd_sel(r_ex.rs1, r_mem, r_wb);
    assign bus.fwd_b        = r_ex.uses_rs2 ? fwd_sel(r_ex.rs2, r_mem, r_wb) : 2'b00;
    assign bus.stall_cnt    = r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state         <= w_next_state;
            r_ex.valid      <= bus.id_valid & ~w_bubble;
            r_ex.rd         <= bus.id_rd;
            r_ex.rs1        <= bus.id_rs1;
            r_ex.rs2        <= bus.id_rs2;
            r_ex.uses_rs2   <= bus.id_uses_rs2;
            r_ex.reg_write  <= bus.id_reg_write;
            r_ex.mem_read   <= bus.id_mem_read;
            r_mem           <= r_ex;
            r_wb            <= r_mem;
            if (w_count_stall && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
endmodule
`default_nettype wire
